// File: rtl/tdc_interval_calc.sv
// Merges the start/stop fine bins and the coarse count of one TDC measurement into
// an interval in tap units. The result goes out on a valid/ready handshake with error flags.
module tdc_interval_calc #(
  parameter int NUM_TAPS   = 36,
  parameter int NUM_DECODE = 8,
  parameter int COARSE_W   = 16,
  parameter int OUT_W      = 24,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_finished,
  input  logic [NUM_DECODE-1:0] start_bin,
  input  logic                  stop_finished,
  input  logic [NUM_DECODE-1:0] stop_bin,
  input  logic                  coarse_valid,
  input  logic [COARSE_W-1:0]   coarse_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_interval,
  output logic [2:0]            out_err,
  output logic                  busy,
  output logic                  dropped
);
  typedef enum logic [1:0] {IDLE, WAIT, CALC, OUT} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = OUT_W + 2;

  state_t                state;
  logic                  have_start, have_stop, have_coarse;
  logic [NUM_DECODE-1:0] start_q, stop_q;
  logic [COARSE_W-1:0]   coarse_q;
  logic [TW-1:0]         tcnt;

  logic          any_pulse, all_set, neg, ovf, no_edge;
  logic [TW-1:0] tcnt_nxt;
  logic [SW-1:0] sum;

  assign any_pulse = start_finished | stop_finished | coarse_valid;
  // True when the flags plus this cycle's pulses complete the set.
  assign all_set   = (have_start | start_finished) & (have_stop | stop_finished) &
                     (have_coarse | coarse_valid);
  assign tcnt_nxt  = tcnt + 1'b1;

  // Unsigned arithmetic at OUT_W+2 bits; the MSB is the sign of start-stop underflow.
  assign sum     = SW'(coarse_q) * SW'(NUM_TAPS) + SW'(start_q) - SW'(stop_q);
  assign neg     = sum[SW-1];
  assign ovf     = ~sum[SW-1] & sum[SW-2];
  assign no_edge = (start_q == '0) | (stop_q == '0);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      have_start   <= 1'b0;
      have_stop    <= 1'b0;
      have_coarse  <= 1'b0;
      start_q      <= '0;
      stop_q       <= '0;
      coarse_q     <= '0;
      tcnt         <= '0;
      out_valid    <= 1'b0;
      out_interval <= '0;
      out_err      <= '0;
      dropped      <= 1'b0;
    end else begin
      case (state)
        IDLE, WAIT: begin
          // A repeated pulse for an already-captured input keeps the first value.
          if (start_finished && !have_start) begin
            start_q    <= start_bin;
            have_start <= 1'b1;
          end
          if (stop_finished && !have_stop) begin
            stop_q    <= stop_bin;
            have_stop <= 1'b1;
          end
          if (coarse_valid && !have_coarse) begin
            coarse_q    <= coarse_count;
            have_coarse <= 1'b1;
          end
          if (state == IDLE) begin
            if (all_set)        state <= CALC;
            else if (any_pulse) state <= WAIT;
          end else begin
            tcnt <= tcnt_nxt;
            if (all_set) begin
              state <= CALC;
            end else if (tcnt_nxt == TW'(TIMEOUT)) begin
              state        <= OUT;
              out_valid    <= 1'b1;
              out_interval <= '0;
              out_err      <= 3'b010;
            end
          end
        end
        CALC: begin
          if (any_pulse) dropped <= 1'b1;
          out_err      <= {neg | ovf, 1'b0, no_edge};
          out_interval <= neg ? '0 : (ovf ? '1 : sum[OUT_W-1:0]);
          out_valid    <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (any_pulse) dropped <= 1'b1;
          if (out_ready) begin
            out_valid   <= 1'b0;
            have_start  <= 1'b0;
            have_stop   <= 1'b0;
            have_coarse <= 1'b0;
            tcnt        <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdc_interval_calc.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on each handshake.
module tb_tdc_interval_calc;
  logic        clk, rst;
  logic        start_finished, stop_finished, coarse_valid;
  logic [7:0]  start_bin, stop_bin;
  logic [15:0] coarse_count;
  logic        out_valid, out_ready, busy, dropped;
  logic [23:0] out_interval;
  logic [2:0]  out_err;

  tdc_interval_calc dut (
    .clk(clk), .rst(rst),
    .start_finished(start_finished), .start_bin(start_bin),
    .stop_finished(stop_finished), .stop_bin(stop_bin),
    .coarse_valid(coarse_valid), .coarse_count(coarse_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_interval(out_interval), .out_err(out_err),
    .busy(busy), .dropped(dropped)
  );

  typedef struct { int iv; int err; int cyc; } exp_t;
  exp_t q[$];
  int   pass_cnt = 0, total_cnt = 0;
  int   cyc = 0, rise = -1;
  logic vprev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: records when out_valid rises, checks the result on each handshake.
  always @(negedge clk) begin
    if (out_valid && !vprev) rise = cyc;
    vprev = out_valid;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("interval", 32'(out_interval), e.iv);
        chk("err", 32'(out_err), e.err);
        if (e.cyc >= 0) chk("latency", rise, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit s, input logic [7:0] sb, input bit p, input logic [7:0] pb,
                       input bit c, input logic [15:0] cc);
    start_finished = s; start_bin = sb;
    stop_finished  = p; stop_bin  = pb;
    coarse_valid   = c; coarse_count = cc;
    step();
    start_finished = 0; stop_finished = 0; coarse_valid = 0;
  endtask

  task automatic push(input int iv, input int err, input int c);
    exp_t e;
    e.iv = iv; e.err = err; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin step(); n++; end
    if (q.size() != 0) begin
      chk("drain_timeout", 0, 1);
      q.delete();
    end
  endtask

  initial begin
    int k;
    rst = 0; out_ready = 1;
    start_finished = 0; stop_finished = 0; coarse_valid = 0;
    start_bin = 0; stop_bin = 0; coarse_count = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_interval", out_interval, 0);
    chk("rst_err", out_err, 0);
    chk("rst_dropped", dropped, 0);
    rst = 1;
    step();

    // 1: staggered pulses, duplicate start in WAIT ignored -> 5*36+10-4
    drive(1, 10, 0, 0, 0, 0);
    drive(1, 20, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 5);
    step();
    k = cyc;
    push(186, 0, k + 2);
    drive(0, 0, 1, 4, 0, 0);
    wait_drain(20);
    chk("t1_valid_one_cycle", out_valid, 0);
    chk("t1_busy_idle", busy, 0);
    chk("t1_no_drop", dropped, 0);

    // 2: all three together, negative sum
    k = cyc;
    push(0, 3'b100, k + 2);
    drive(1, 3, 1, 9, 1, 0);
    wait_drain(20);

    // 3: no stop -> timeout
    k = cyc;
    push(0, 3'b010, k + 1024);
    drive(1, 10, 0, 0, 1, 7);
    wait_drain(1100);

    // 4: start bin 0 -> no-edge flag, 2*36-5
    drive(1, 0, 1, 5, 0, 0);
    k = cyc;
    push(67, 3'b001, k + 2);
    drive(0, 0, 0, 0, 1, 2);
    wait_drain(20);

    // 5: backpressure with a dropped pulse during OUT
    out_ready = 0;
    k = cyc;
    push(41, 0, k + 2);
    drive(1, 7, 1, 2, 1, 1);
    step();
    chk("t5_valid_up", out_valid, 1);
    drive(1, 50, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_interval", out_interval, 41);
      chk("t5_hold_err", out_err, 0);
      step();
    end
    chk("t5_dropped", dropped, 1);
    out_ready = 1;
    wait_drain(20);
    chk("t5_busy_idle", busy, 0);
    // stale flags would complete this measurement early
    drive(0, 0, 0, 0, 1, 3);
    step();
    drive(0, 0, 1, 1, 0, 0);
    chk("t5_waiting", busy, 1);
    step();
    k = cyc;
    push(109, 0, k + 2);
    drive(1, 2, 0, 0, 0, 0);
    wait_drain(20);

    // 6a: async reset mid-OUT clears result and sticky dropped
    out_ready = 0;
    drive(1, 1, 1, 1, 1, 2);
    step();
    chk("t6_valid_up", out_valid, 1);
    drive(0, 0, 1, 8, 0, 0);
    chk("t6_dropped_set", dropped, 1);
    #2 rst = 0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_interval", out_interval, 0);
    chk("t6_out_err", out_err, 0);
    chk("t6_out_dropped", dropped, 0);
    chk("t6_out_busy", busy, 0);
    #2 rst = 1;
    step();
    out_ready = 1;

    // 6b: async reset mid-WAIT
    drive(1, 10, 0, 0, 0, 0);
    step(); step();
    chk("t6_wait_busy_pre", busy, 1);
    #2 rst = 0;
    #1;
    chk("t6_wait_busy", busy, 0);
    chk("t6_wait_valid", out_valid, 0);
    #2 rst = 1;
    step();

    // full measurement after release
    drive(1, 10, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5);
    k = cyc;
    push(186, 0, k + 2);
    drive(0, 0, 1, 4, 0, 0);
    wait_drain(20);

    repeat (3) step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
